mem_interface: RTL and testbench

//  MAR/MDR memory interface between the CPU datapath bus and the synchronous 512x32 ram.

---
 rtl/mem_interface.sv | 85 ++++++++
 tb/tb_mem_interface.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mem_interface.sv
// mem_interface: MAR/MDR bridge between the datapath bus and a synchronous
// single-port ram with a registered read port. Sequences one-word read and
// write transactions and pulses done when each one completes.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting; MAR/MDR loads and new requests accepted
// S_RD_ISSUE | ram_read high; ram registers mem[MAR] at the closing edge
// S_RD_CAP   | ram_rdata valid; MDR captures it at the closing edge
// S_WR_ISSUE | ram_write high; ram writes MDR to mem[MAR] at the closing edge
// S_DONE     | done pulse; behaves like IDLE for loads and new requests
module mem_interface #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] bus_in,
    input  logic                  mar_in,
    input  logic                  mdr_in,
    input  logic                  rd_req,
    input  logic                  wr_req,
    output logic [DATA_WIDTH-1:0] mdr_q,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  ram_read,
    output logic                  ram_write
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_ISSUE = 3'd1,
        S_RD_CAP   = 3'd2,
        S_WR_ISSUE = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] mar_q;

    // Sequencer, MAR and MDR; loads are only honoured while not mid-transaction
    // so the address and data seen by the ram stay stable.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S_IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (mar_in) mar_q <= bus_in[ADDR_WIDTH-1:0];
                    if (mdr_in) mdr_q <= bus_in;
                    // Read wins a tie; a dropped write must be reissued.
                    if (rd_req)      state_q <= S_RD_ISSUE;
                    else if (wr_req) state_q <= S_WR_ISSUE;
                    else             state_q <= S_IDLE;
                end
                S_RD_ISSUE: state_q <= S_RD_CAP;
                S_RD_CAP: begin
                    mdr_q   <= ram_rdata;
                    state_q <= S_DONE;
                end
                S_WR_ISSUE: state_q <= S_DONE;
                default:    state_q <= S_IDLE;
            endcase
        end
    end

    // Strobes decode from the state register only, so clear drops them at once
    // and no request input reaches an output combinationally.
    always_comb begin
        ram_read  = (state_q == S_RD_ISSUE);
        ram_write = (state_q == S_WR_ISSUE);
        done      = (state_q == S_DONE);
        busy      = (state_q == S_RD_ISSUE) || (state_q == S_RD_CAP) ||
                    (state_q == S_WR_ISSUE);
    end

    assign ram_address = mar_q;
    assign ram_wdata   = mdr_q;

endmodule

// File: tb/tb_mem_interface.sv
// Directed bench for mem_interface with a behavioural 512x32 ram that has a
// registered read port.
module tb_mem_interface;

    logic        clk;
    logic        clear;
    logic [31:0] bus_in;
    logic        mar_in, mdr_in, rd_req, wr_req;
    logic [31:0] mdr_q;
    logic        busy, done;
    logic [8:0]  ram_address;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_read, ram_write;

    logic [31:0] mem [0:511];
    logic        ld_en;
    logic [8:0]  ld_addr;
    logic [31:0] ld_data;
    int          wr_cnt = 0;
    int          w0;
    int          n_cmp = 0;
    int          n_err = 0;

    mem_interface #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) dut (
        .clock       (clk),
        .clear       (clear),
        .bus_in      (bus_in),
        .mar_in      (mar_in),
        .mdr_in      (mdr_in),
        .rd_req      (rd_req),
        .wr_req      (wr_req),
        .mdr_q       (mdr_q),
        .busy        (busy),
        .done        (done),
        .ram_address (ram_address),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .ram_read    (ram_read),
        .ram_write   (ram_write)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ram model: registered read, synchronous write, plus a bench preload port
    always @(posedge clk) begin
        if (ld_en)     mem[ld_addr] <= ld_data;
        if (ram_write) mem[ram_address] <= ram_wdata;
        if (ram_read)  ram_rdata <= mem[ram_address];
        if (ram_write) wr_cnt <= wr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        clear = 1'b1; bus_in = '0; mar_in = 0; mdr_in = 0; rd_req = 0; wr_req = 0;
        ld_en = 0; ld_addr = '0; ld_data = '0; w0 = 0;
        step();
        ld_en = 1; ld_addr = 9'h069; ld_data = 32'h0000_1234; step();
        ld_addr = 9'h1FF; ld_data = 32'h5A5A_5A5A; step();
        ld_en = 0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd", 32'(ram_read), 32'd0);
        chk("rst_wr", 32'(ram_write), 32'd0);
        chk("rst_mdr", mdr_q, 32'd0);
        chk("rst_mar", 32'(ram_address), 32'd0);
        clear = 0; step();

        // read of preloaded word
        bus_in = 32'h69; mar_in = 1; rd_req = 1; step();
        chk("rd_issue_rd", 32'(ram_read), 32'd1);
        chk("rd_issue_busy", 32'(busy), 32'd1);
        chk("rd_issue_addr", 32'(ram_address), 32'h69);
        mar_in = 0; rd_req = 0; bus_in = '0; step();
        chk("rd_cap_rd", 32'(ram_read), 32'd0);
        chk("rd_cap_done", 32'(done), 32'd0);
        step();
        chk("rd_done", 32'(done), 32'd1);
        chk("rd_done_busy", 32'(busy), 32'd0);
        chk("rd_mdr", mdr_q, 32'h0000_1234);
        step();
        chk("rd_done_pulse", 32'(done), 32'd0);

        // write then readback
        bus_in = 32'h8E; mar_in = 1; step();
        mar_in = 0; bus_in = 32'hDEAD_BEEF; mdr_in = 1; wr_req = 1; w0 = wr_cnt; step();
        chk("wr_issue_wr", 32'(ram_write), 32'd1);
        chk("wr_issue_wdata", ram_wdata, 32'hDEAD_BEEF);
        chk("wr_issue_addr", 32'(ram_address), 32'h8E);
        mdr_in = 0; wr_req = 0; step();
        chk("wr_done", 32'(done), 32'd1);
        chk("wr_done_wr", 32'(ram_write), 32'd0);
        chk("wr_mem", mem[9'h08E], 32'hDEAD_BEEF);
        chk("wr_count", 32'(wr_cnt - w0), 32'd1);
        bus_in = '0; mdr_in = 1; rd_req = 1; step();
        chk("rb_mdr_cleared", mdr_q, 32'd0);
        mdr_in = 0; rd_req = 0; step(); step();
        chk("rb_done", 32'(done), 32'd1);
        chk("rb_mdr", mdr_q, 32'hDEAD_BEEF);

        // simultaneous requests (accepted from DONE), request during RD_CAP
        bus_in = 32'h69; mar_in = 1; rd_req = 1; wr_req = 1; w0 = wr_cnt; step();
        chk("col_rd", 32'(ram_read), 32'd1);
        chk("col_wr", 32'(ram_write), 32'd0);
        mar_in = 0; wr_req = 0; bus_in = 32'hAAAA_5555; mdr_in = 1; rd_req = 1; step();
        chk("col_cap_busy", 32'(busy), 32'd1);
        rd_req = 0; mdr_in = 0; step();
        chk("col_done", 32'(done), 32'd1);
        chk("col_mdr", mdr_q, 32'h0000_1234);
        step();
        chk("col_no_requeue", 32'(busy), 32'd0);
        chk("col_wr_count", 32'(wr_cnt - w0), 32'd0);
        chk("col_mdr_hold", mdr_q, 32'h0000_1234);

        // MAR load attempted mid-read
        bus_in = 32'h8E; mar_in = 1; rd_req = 1; step();
        bus_in = 32'h1FF; rd_req = 0; step();
        chk("busy_mar_addr", 32'(ram_address), 32'h8E);
        mar_in = 0; step();
        chk("busy_mar_done", 32'(done), 32'd1);
        chk("busy_mar_mdr", mdr_q, 32'hDEAD_BEEF);
        chk("busy_mar_hold", 32'(ram_address), 32'h8E);

        // back-to-back writes, upper bus bits ignored on MAR load
        bus_in = 32'hFFFF_F069; mar_in = 1; step();
        chk("b2b_mar", 32'(ram_address), 32'h069);
        mar_in = 0; bus_in = 32'hCAFE_F00D; mdr_in = 1; wr_req = 1; w0 = wr_cnt; step();
        chk("b2b_wr1", 32'(ram_write), 32'd1);
        mdr_in = 0; step();
        chk("b2b_done1", 32'(done), 32'd1);
        step();
        chk("b2b_wr2", 32'(ram_write), 32'd1);
        chk("b2b_wr2_done", 32'(done), 32'd0);
        wr_req = 0; step();
        chk("b2b_done2", 32'(done), 32'd1);
        chk("b2b_count", 32'(wr_cnt - w0), 32'd2);
        chk("b2b_mem", mem[9'h069], 32'hCAFE_F00D);
        step();

        // clear during RD_ISSUE
        rd_req = 1; step();
        chk("clr_pre_rd", 32'(ram_read), 32'd1);
        rd_req = 0;
        #2 clear = 1;
        #1;
        chk("clr_rd", 32'(ram_read), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_done", 32'(done), 32'd0);
        chk("clr_mdr", mdr_q, 32'd0);
        chk("clr_mar", 32'(ram_address), 32'd0);
        step(); step();
        clear = 0; step();
        chk("clr_idle", 32'(busy), 32'd0);
        chk("clr_no_done", 32'(done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
